// File: rtl/vram_h2f_sink.sv
// HPS-to-FPGA VRAM write sink: registered byte-enabled writes into the back bank of a
// ping-pong VRAM pair, 2-cycle PPU read port on the front bank, vblank-deferred swap.
module vram_h2f_sink #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_W-1:0]     i_h2f_wraddr,
  input  logic                  i_h2f_wren,
  input  logic [DATA_W-1:0]     i_h2f_wrdata,
  input  logic [DATA_W/8-1:0]   i_h2f_byteena,
  input  logic                  i_swap_req,
  input  logic                  i_vblank_start,
  input  logic [ADDR_W-1:0]     i_ppu_rdaddr,
  output logic [DATA_W-1:0]     o_ppu_rddata,
  output logic                  o_front_sel,
  output logic                  o_swap_pending,
  output logic                  o_swap_done,
  output logic [CNT_W-1:0]      o_wr_count
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_SWAP    = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                r_front_sel;
  logic                w_swap_now;
  logic                w_cap_bank;

  logic                r_wr_valid;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [BE_W-1:0]     r_wr_be;
  logic                r_wr_bank;
  logic [CNT_W-1:0]    r_wr_cnt;

  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_rd_bank;

  logic [DATA_W-1:0]   r_bank0 [DEPTH];
  logic [DATA_W-1:0]   r_bank1 [DEPTH];

  assign w_swap_now = (r_state == ST_SWAP);
  // A write captured on the swap cycle belongs to the new back bank.
  assign w_cap_bank = ~(r_front_sel ^ w_swap_now);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_swap_req && i_vblank_start) w_state_nxt = ST_SWAP;
        else if (i_swap_req)              w_state_nxt = ST_PENDING;
      end
      ST_PENDING: if (i_vblank_start) w_state_nxt = ST_SWAP;
      ST_SWAP:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_front_sel <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_swap_now) r_front_sel <= ~r_front_sel;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_valid <= 1'b0;
      r_wr_cnt   <= '0;
    end else begin
      r_wr_valid <= i_h2f_wren;
      if (i_h2f_wren) begin
        r_wr_addr <= i_h2f_wraddr;
        r_wr_data <= i_h2f_wrdata;
        r_wr_be   <= i_h2f_byteena;
        r_wr_bank <= w_cap_bank;
      end
      if (w_swap_now)
        r_wr_cnt <= {{(CNT_W-1){1'b0}}, i_h2f_wren};
      else if (i_h2f_wren && (r_wr_cnt != {CNT_W{1'b1}}))
        r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end

  // Commit stage; a reset on the commit cycle drops the in-flight write.
  always_ff @(posedge i_clk) begin
    if (r_wr_valid && !i_rst) begin
      for (int b = 0; b < BE_W; b++) begin
        if (r_wr_be[b]) begin
          if (r_wr_bank) r_bank1[r_wr_addr][8*b +: 8] <= r_wr_data[8*b +: 8];
          else           r_bank0[r_wr_addr][8*b +: 8] <= r_wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_addr    <= '0;
      r_rd_bank    <= 1'b0;
      o_ppu_rddata <= '0;
    end else begin
      r_rd_addr    <= i_ppu_rdaddr;
      r_rd_bank    <= r_front_sel;
      o_ppu_rddata <= r_rd_bank ? r_bank1[r_rd_addr] : r_bank0[r_rd_addr];
    end
  end

  assign o_front_sel    = r_front_sel;
  assign o_swap_pending = (r_state == ST_PENDING);
  assign o_swap_done    = w_swap_now;
  assign o_wr_count     = r_wr_cnt;

endmodule

// File: tb/tb_vram_h2f_sink.sv
// Randomized and directed bench for vram_h2f_sink, checked every cycle against a
// behavioural model of banks, swap timing and the saturating write counter.
module tb_vram_h2f_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] wrAddr;
  logic        wrEn;
  logic [63:0] wrData;
  logic [7:0]  byteEna;
  logic        swapReq;
  logic        vblankStart;
  logic [12:0] rdAddr;

  logic [63:0] rdData,  rdData4;
  logic        frontSel, frontSel4;
  logic        swapPending, swapPending4;
  logic        swapDone, swapDone4;
  logic [13:0] wrCount;
  logic [3:0]  wrCount4;

  int compareCount = 0;
  int failCount    = 0;
  int donePulses   = 0;

  // Reference model state
  logic [63:0] mMem   [2][8192];
  bit          mKnown [2][8192];
  bit          mFront, mPending, mSwapCycle;
  int          mCount, mCount4;
  bit          mWrValid, mWrBank;
  logic [12:0] mWrAddr;
  logic [63:0] mWrData;
  logic [7:0]  mWrBe;
  logic [12:0] mRdAddr;
  bit          mRdBank;
  logic [63:0] expRd;
  bit          expRdKnown;

  vram_h2f_sink dut (
    .i_clk(clk), .i_rst(rst), .i_h2f_wraddr(wrAddr), .i_h2f_wren(wrEn),
    .i_h2f_wrdata(wrData), .i_h2f_byteena(byteEna), .i_swap_req(swapReq),
    .i_vblank_start(vblankStart), .i_ppu_rdaddr(rdAddr), .o_ppu_rddata(rdData),
    .o_front_sel(frontSel), .o_swap_pending(swapPending), .o_swap_done(swapDone),
    .o_wr_count(wrCount)
  );

  vram_h2f_sink #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_h2f_wraddr(wrAddr), .i_h2f_wren(wrEn),
    .i_h2f_wrdata(wrData), .i_h2f_byteena(byteEna), .i_swap_req(swapReq),
    .i_vblank_start(vblankStart), .i_ppu_rdaddr(rdAddr), .o_ppu_rddata(rdData4),
    .o_front_sel(frontSel4), .o_swap_pending(swapPending4), .o_swap_done(swapDone4),
    .o_wr_count(wrCount4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compareCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs that were present at that edge.
  task automatic modelStep();
    if (rst) begin
      mFront = 0; mPending = 0; mSwapCycle = 0; mCount = 0; mCount4 = 0;
      mWrValid = 0; mRdAddr = '0; mRdBank = 0; expRd = '0; expRdKnown = 1;
    end else begin
      expRd      = mMem[mRdBank][mRdAddr];
      expRdKnown = mKnown[mRdBank][mRdAddr];
      if (mWrValid) begin
        for (int b = 0; b < 8; b++)
          if (mWrBe[b]) mMem[mWrBank][mWrAddr][8*b +: 8] = mWrData[8*b +: 8];
        if (mWrBe == 8'hFF) mKnown[mWrBank][mWrAddr] = 1;
      end
      mRdAddr = rdAddr;
      mRdBank = mFront;
      if (mSwapCycle) begin
        mFront  = !mFront;
        mCount  = 0;
        mCount4 = 0;
      end
      mWrValid = wrEn;
      if (wrEn) begin
        mWrAddr = wrAddr; mWrData = wrData; mWrBe = byteEna; mWrBank = !mFront;
        if (mCount < 16383) mCount++;
        if (mCount4 < 15) mCount4++;
      end
      if (mSwapCycle) begin
        mSwapCycle = 0;
        mPending   = 0;
      end else if ((mPending || swapReq) && vblankStart) begin
        mSwapCycle = 1;
        mPending   = 0;
      end else begin
        mPending = mPending || swapReq;
      end
    end
  endtask

  task automatic applyStimulus(input bit rstV, input bit wrenV, input logic [12:0] addrV,
                               input logic [63:0] dataV, input logic [7:0] beV,
                               input bit swapV, input bit vblankV, input logic [12:0] rdV);
    @(negedge clk);
    rst = rstV; wrEn = wrenV; wrAddr = addrV; wrData = dataV; byteEna = beV;
    swapReq = swapV; vblankStart = vblankV; rdAddr = rdV;
    @(posedge clk);
    #1;
    modelStep();
    donePulses += int'(swapDone);
    checkOutput("front_sel", 64'(frontSel), 64'(mFront));
    checkOutput("swap_pending", 64'(swapPending), 64'(mPending));
    checkOutput("swap_done", 64'(swapDone), 64'(mSwapCycle));
    checkOutput("wr_count", 64'(wrCount), 64'(mCount));
    checkOutput("wr_count_w4", 64'(wrCount4), 64'(mCount4));
    checkOutput("front_sel_w4", 64'(frontSel4), 64'(mFront));
    if (expRdKnown) begin
      checkOutput("ppu_rddata", rdData, expRd);
      checkOutput("ppu_rddata_w4", rdData4, expRd);
    end
  endtask

  task automatic idle(input int n, input logic [12:0] rdV);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, '0, 0, 0, rdV);
  endtask

  task automatic writeWord(input logic [12:0] a, input logic [63:0] d, input logic [7:0] be);
    applyStimulus(0, 1, a, d, be, 0, 0, '0);
  endtask

  task automatic swapNow();
    applyStimulus(0, 0, '0, '0, '0, 1, 1, '0);
    idle(1, '0);
  endtask

  // Issue a read and return to the cycle where its data is valid.
  task automatic readWord(input logic [12:0] a);
    applyStimulus(0, 0, '0, '0, '0, 0, 0, a);
    idle(1, a);
  endtask

  initial begin
    rst = 1; wrEn = 0; wrAddr = '0; wrData = '0; byteEna = '0;
    swapReq = 0; vblankStart = 0; rdAddr = '0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 8192; a++) begin mMem[b][a] = '0; mKnown[b][a] = 0; end

    applyStimulus(1, 0, '0, '0, '0, 0, 0, '0);
    applyStimulus(1, 0, '0, '0, '0, 0, 0, '0);
    checkOutput("reset_rddata", rdData, 64'h0);
    checkOutput("reset_count", 64'(wrCount), 64'h0);

    // Preload addresses 0..31 in both banks
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = 0; a < 32; a++) writeWord(13'(a), {$urandom, $urandom}, 8'hFF);
      swapNow();
    end

    // Full-word write, swap in the same cycle as vblank, read back on new front
    donePulses = 0;
    writeWord(13'h0010, 64'h1122334455667788, 8'hFF);
    swapNow();
    readWord(13'h0010);
    checkOutput("t1_readback", rdData, 64'h1122334455667788);
    checkOutput("t1_done_pulses", 64'(donePulses), 64'd1);

    // Partial byte enables, and a zero-enable write that still counts
    writeWord(13'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    writeWord(13'h0000, 64'h0, 8'h0F);
    writeWord(13'h0000, 64'h0, 8'h00);
    idle(1, '0);
    checkOutput("t2_count", 64'(wrCount), 64'd3);
    swapNow();
    readWord(13'h0000);
    checkOutput("t2_be_merge", rdData, 64'hFFFF_FFFF_0000_0000);

    // Deferred swap with a redundant request while pending
    donePulses = 0;
    applyStimulus(0, 0, '0, '0, '0, 1, 0, '0);
    idle(9, '0);
    applyStimulus(0, 0, '0, '0, '0, 1, 0, '0);
    idle(29, '0);
    checkOutput("t3_pending", 64'(swapPending), 64'd1);
    applyStimulus(0, 0, '0, '0, '0, 0, 1, '0);
    idle(3, '0);
    applyStimulus(0, 0, '0, '0, '0, 0, 1, '0);
    idle(2, '0);
    checkOutput("t3_done_pulses", 64'(donePulses), 64'd1);

    // Writes straddling the swap cycle
    applyStimulus(0, 1, 13'd5, 64'hA5A5_0000_1234_5678, 8'hFF, 1, 1, '0);
    applyStimulus(0, 1, 13'd6, 64'h0BAD_F00D_0BAD_F00D, 8'hFF, 0, 0, '0);
    checkOutput("t4_count_after_swap", 64'(wrCount), 64'd1);
    readWord(13'd5);
    checkOutput("t4_old_back_read", rdData, 64'hA5A5_0000_1234_5678);
    swapNow();
    readWord(13'd6);
    checkOutput("t4_new_back_read", rdData, 64'h0BAD_F00D_0BAD_F00D);

    // Long write burst: full counter does not saturate, 4-bit one does
    swapNow();
    for (int i = 0; i < 8200; i++) writeWord(13'($urandom_range(0, 31)), {$urandom, $urandom}, 8'hFF);
    checkOutput("t5_count_8200", 64'(wrCount), 64'd8200);
    checkOutput("t5_count_w4_sat", 64'(wrCount4), 64'd15);

    // Reset in the middle of a write with a swap pending
    applyStimulus(0, 0, '0, '0, '0, 1, 0, '0);
    writeWord(13'd7, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    applyStimulus(1, 1, 13'd8, 64'hCAFE_CAFE_CAFE_CAFE, 8'hFF, 0, 0, '0);
    checkOutput("t6_front", 64'(frontSel), 64'd0);
    checkOutput("t6_pending", 64'(swapPending), 64'd0);
    checkOutput("t6_count", 64'(wrCount), 64'd0);
    swapNow();
    readWord(13'd7);
    readWord(13'd8);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
                    13'($urandom_range(0, 31)), {$urandom, $urandom}, 8'($urandom),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0),
                    13'($urandom_range(0, 31)));
    end
    idle(3, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
